// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Read-owner encoding tracks which port a pending RAM read belongs to.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 32;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DBG
    } owner_e;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of cycles the debug port has waited for a grant.
// Raises starved once the count reaches MAX_WAIT while debug still requests.
module dmem_starve_cnt
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic starved
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count;

    // count denied debug cycles, clear on grant or when debug lets go
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign starved = dbg_req && (count == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU, debug/loader) in front of a single-port data RAM.
// Define DMEM_ARB_STARVE_EN to add a debug starvation limit with forced grant.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_wr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    logic              force_dbg;
    logic              dbg_issue;
    logic              cpu_issue;
    owner_e            owner;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dbg_hold;

    assign dbg_issue = !reset && dbg_req && (!cpu_req || force_dbg);
    assign cpu_issue = !reset && cpu_req && !dbg_issue;
    assign dbg_gnt   = dbg_issue;

`ifdef DMEM_ARB_STARVE_EN
    dmem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .dbg_req (dbg_req),
        .dbg_gnt (dbg_issue),
        .starved (force_dbg)
    );

    assign cpu_stall = cpu_req && dbg_issue;
`else
    assign force_dbg = 1'b0;
    assign cpu_stall = 1'b0;
`endif

    // RAM command mux; idle keeps the last issued address on the bus
    always_comb begin
        mem_addr = last_addr;
        mem_data = '0;
        mem_wren = 1'b0;
        if (reset) begin
            mem_addr = '0;
        end else if (cpu_issue) begin
            mem_addr = cpu_addr;
            mem_data = cpu_wdata;
            mem_wren = cpu_wr;
        end else if (dbg_issue) begin
            mem_addr = dbg_addr;
            mem_data = dbg_wdata;
            mem_wren = dbg_wr;
        end
    end

    // track read ownership, last address and per-port held read data
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_NONE;
            last_addr <= '0;
            cpu_hold  <= '0;
            dbg_hold  <= '0;
        end else begin
            if (cpu_issue && !cpu_wr) begin
                owner <= OWN_CPU;
            end else if (dbg_issue && !dbg_wr) begin
                owner <= OWN_DBG;
            end else begin
                owner <= OWN_NONE;
            end
            if (cpu_issue || dbg_issue) begin
                last_addr <= mem_addr;
            end
            if (owner == OWN_CPU) begin
                cpu_hold <= mem_q;
            end
            if (owner == OWN_DBG) begin
                dbg_hold <= mem_q;
            end
        end
    end

    assign cpu_rvalid = !reset && (owner == OWN_CPU);
    assign dbg_rvalid = !reset && (owner == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_q : (reset ? '0 : cpu_hold);
    assign dbg_rdata  = dbg_rvalid ? mem_q : (reset ? '0 : dbg_hold);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural RAM and model.
// Honors DMEM_ARB_STARVE_EN to pick the expected arbitration policy.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_wr, dbg_req, dbg_wr;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_data, mem_q;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_wren;

    dmem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_wr     (dbg_wr),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port RAM, registered read, read-before-write
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            m_wait  = 0;
    int            m_owner = 0;
    logic [DW-1:0] m_rd    = '0;
    logic [DW-1:0] m_chold = '0;
    logic [DW-1:0] m_dhold = '0;
    logic [AW-1:0] m_last  = '0;

    // prediction for the current cycle
    logic          g_r, g_dr, p_cpu, p_dbg, p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic cr, input logic cw,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd);
        logic dwin;
        logic [DW-1:0] e_cd, e_dd;
        reset = r; cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_wr = dw; dbg_addr = da; dbg_wdata = dd;
        #4;
        dwin  = !r && dr && (!cr || (STARVE && m_wait >= MW));
        p_dbg = dwin;
        p_cpu = !r && cr && !dwin;
        p_wr  = (p_cpu && cw) || (p_dbg && dw);
        p_addr = r ? '0 : p_cpu ? ca : p_dbg ? da : m_last;
        p_data = p_cpu ? cd : dd;
        g_r = r; g_dr = dr;
        e_cd = r ? '0 : (m_owner == 1) ? m_rd : m_chold;
        e_dd = r ? '0 : (m_owner == 2) ? m_rd : m_dhold;
        chk("dbg_gnt", 64'(dbg_gnt), 64'(p_dbg));
        chk("cpu_stall", 64'(cpu_stall), 64'(cr && dwin));
        chk("mem_wren", 64'(mem_wren), 64'(p_wr));
        chk("mem_addr", 64'(mem_addr), 64'(p_addr));
        if (p_wr) chk("mem_data", 64'(mem_data), 64'(p_data));
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(!r && m_owner == 1));
        chk("dbg_rvalid", 64'(dbg_rvalid), 64'(!r && m_owner == 2));
        chk("cpu_rdata", 64'(cpu_rdata), 64'(e_cd));
        chk("dbg_rdata", 64'(dbg_rdata), 64'(e_dd));
    endtask

    task automatic tick;
        @(posedge clk);
        if (g_r) begin
            m_wait = 0; m_owner = 0; m_last = '0;
            m_chold = '0; m_dhold = '0;
        end else begin
            if (m_owner == 1) m_chold = m_rd;
            if (m_owner == 2) m_dhold = m_rd;
            if (p_cpu || p_dbg) begin
                m_last  = p_addr;
                m_owner = p_wr ? 0 : (p_cpu ? 1 : 2);
                m_rd    = ref_mem[p_addr];
                if (p_wr) ref_mem[p_addr] = p_data;
            end else begin
                m_owner = 0;
            end
            if (g_dr && !p_dbg) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
            else m_wait = 0;
        end
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    typedef struct {
        logic          r, cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          e_gnt, e_stall, e_wren;
    } tv_t;

    tv_t tv [8];

    initial begin
        tv[0] = '{1'b0,1'b1,1'b0,8'h05,32'h0,       1'b0,1'b0,8'h00,32'h0,       1'b0,1'b0,1'b0};
        tv[1] = '{1'b0,1'b1,1'b1,8'h06,32'hA5A5A5A5,1'b0,1'b0,8'h00,32'h0,       1'b0,1'b0,1'b1};
        tv[2] = '{1'b0,1'b0,1'b0,8'h00,32'h0,       1'b1,1'b0,8'h07,32'h0,       1'b1,1'b0,1'b0};
        tv[3] = '{1'b0,1'b0,1'b0,8'h00,32'h0,       1'b1,1'b1,8'h08,32'h0BADF00D,1'b1,1'b0,1'b1};
        tv[4] = '{1'b0,1'b1,1'b1,8'h09,32'h55AA55AA,1'b1,1'b0,8'h0A,32'h0,       1'b0,1'b0,1'b1};
        tv[5] = '{1'b0,1'b0,1'b0,8'h00,32'h0,       1'b0,1'b0,8'h00,32'h0,       1'b0,1'b0,1'b0};
        tv[6] = '{1'b1,1'b1,1'b1,8'h0B,32'h1,       1'b1,1'b1,8'h0C,32'h2,       1'b0,1'b0,1'b0};
        tv[7] = '{1'b0,1'b1,1'b0,8'h0D,32'h0,       1'b1,1'b1,8'h0E,32'h3,       1'b0,1'b0,1'b0};

        // reset with both ports requesting
        drive(1'b1, 1'b1, 1'b1, 8'h44, 32'h1, 1'b1, 1'b1, 8'h55, 32'h2);
        tick;
        drive(1'b1, 1'b1, 1'b1, 8'h44, 32'h1, 1'b1, 1'b1, 8'h55, 32'h2);
        chk("rst_gnt", 64'(dbg_gnt), 64'(0));
        chk("rst_stall", 64'(cpu_stall), 64'(0));
        chk("rst_wren", 64'(mem_wren), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        tick;
        idle;
        chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        chk("rst_dbg_rdata", 64'(dbg_rdata), 64'(0));
        tick;

        // loader fills the whole RAM through the debug port
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'(i), $urandom);
            tick;
        end

        // table vectors
        for (int i = 0; i < 8; i++) begin
            drive(tv[i].r, tv[i].cr, tv[i].cw, tv[i].ca, tv[i].cd,
                  tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
            chk($sformatf("tv%0d_gnt", i), 64'(dbg_gnt), 64'(tv[i].e_gnt));
            chk($sformatf("tv%0d_stall", i), 64'(cpu_stall), 64'(tv[i].e_stall));
            chk($sformatf("tv%0d_wren", i), 64'(mem_wren), 64'(tv[i].e_wren));
            tick;
        end
        idle; tick;

        // CPU write then read of 0x10
        drive(1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        chk("wr10_wren", 64'(mem_wren), 64'(1));
        chk("wr10_addr", 64'(mem_addr), 64'(8'h10));
        tick;
        drive(1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0, '0, '0);
        chk("rd10_wren", 64'(mem_wren), 64'(0));
        chk("rd10_nowrvalid", 64'(cpu_rvalid), 64'(0));
        tick;
        idle;
        chk("rd10_rvalid", 64'(cpu_rvalid), 64'(1));
        chk("rd10_rdata", 64'(cpu_rdata), 64'(32'hDEADBEEF));
        chk("rd10_addr_hold", 64'(mem_addr), 64'(8'h10));
        tick;
        idle;
        chk("rd10_one_shot", 64'(cpu_rvalid), 64'(0));
        chk("rd10_rdata_hold", 64'(cpu_rdata), 64'(32'hDEADBEEF));
        tick;

        // debug-only read of 0x3F
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h3F, 32'h12345678);
        tick;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h3F, '0);
        chk("rd3f_gnt", 64'(dbg_gnt), 64'(1));
        tick;
        idle;
        chk("rd3f_rvalid", 64'(dbg_rvalid), 64'(1));
        chk("rd3f_rdata", 64'(dbg_rdata), 64'(32'h12345678));
        chk("rd3f_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
        tick;

        // both requesting continuously
        for (int c = 0; c < 7; c++) begin
            logic e;
            e = STARVE && (c == 4);
            drive(1'b0, 1'b1, 1'b0, 8'(8'h20 + c), '0, 1'b1, 1'b0, 8'h30, '0);
            chk($sformatf("both_c%0d_gnt", c), 64'(dbg_gnt), 64'(e));
            chk($sformatf("both_c%0d_stall", c), 64'(cpu_stall), 64'(e));
            tick;
        end
        idle; tick;

        // reset right after a CPU read issue
        drive(1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0, '0, '0);
        tick;
        drive(1'b1, 1'b1, 1'b1, 8'h10, 32'h9, 1'b1, 1'b0, 8'h11, '0);
        chk("rstrd_rvalid", 64'(cpu_rvalid), 64'(0));
        chk("rstrd_rdata", 64'(cpu_rdata), 64'(0));
        chk("rstrd_wren", 64'(mem_wren), 64'(0));
        chk("rstrd_addr", 64'(mem_addr), 64'(0));
        chk("rstrd_gnt", 64'(dbg_gnt), 64'(0));
        chk("rstrd_stall", 64'(cpu_stall), 64'(0));
        tick;
        idle;
        chk("rstrd_after", 64'(cpu_rvalid), 64'(0));
        tick;

        // alternating CPU/debug reads of 0x01/0x02
        drive(1'b0, 1'b1, 1'b1, 8'h01, 32'h11110001, 1'b0, 1'b0, '0, '0);
        tick;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h02, 32'h22220002);
        tick;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) idle;
            else if (i % 2 == 0)
                drive(1'b0, 1'b1, 1'b0, 8'h01, '0, 1'b0, 1'b0, '0, '0);
            else
                drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h02, '0);
            if (i > 0 && (i % 2 == 1)) begin
                chk($sformatf("alt%0d_crv", i), 64'(cpu_rvalid), 64'(1));
                chk($sformatf("alt%0d_drv", i), 64'(dbg_rvalid), 64'(0));
                chk($sformatf("alt%0d_cd", i), 64'(cpu_rdata), 64'(32'h11110001));
            end else if (i > 0) begin
                chk($sformatf("alt%0d_crv", i), 64'(cpu_rvalid), 64'(0));
                chk($sformatf("alt%0d_drv", i), 64'(dbg_rvalid), 64'(1));
                chk($sformatf("alt%0d_dd", i), 64'(dbg_rdata), 64'(32'h22220002));
            end
            tick;
        end

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic r, cr, dr;
            int   cp;
            cp = ((n / 100) % 2 == 1) ? 92 : 50;
            r  = ($urandom_range(0, 59) == 0);
            cr = ($urandom_range(0, 99) < cp);
            dr = ($urandom_range(0, 99) < 55);
            drive(r, cr, 1'($urandom_range(0, 2) == 0),
                  8'($urandom_range(0, 255)), $urandom,
                  dr, 1'($urandom_range(0, 2) == 0),
                  8'($urandom_range(0, 255)), $urandom);
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word address width into the data RAM.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter MAX_WAIT, default 4, debug-port cycles waited before forced grant (range 1..15).
REQ-004 clk  in  1  single clock for the block and the data RAM port it drives.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 cpu_req / cpu_wr  in  1 each  CPU access request; write when cpu_wr=1.
REQ-007 cpu_addr  in  ADDR_W  CPU word address; cpu_wdata  in  DATA_W  CPU store data.
REQ-008 cpu_stall  out  1  CPU request not issued this cycle; CPU holds request and PC.
REQ-009 cpu_rdata  out  DATA_W / cpu_rvalid  out  1  CPU load data, valid one cycle after issue.
REQ-010 dbg_req / dbg_wr  in  1 each  debug/loader request; write when dbg_wr=1.
REQ-011 dbg_addr  in  ADDR_W; dbg_wdata  in  DATA_W  debug address and write data.
REQ-012 dbg_gnt  out  1  debug request issued to RAM this cycle.
REQ-013 dbg_rdata  out  DATA_W / dbg_rvalid  out  1  debug load data, valid one cycle after issue.
REQ-014 mem_addr  out  ADDR_W; mem_data  out  DATA_W; mem_wren  out  1  single-port RAM command.
REQ-015 mem_q  in  DATA_W  RAM read data, registered by RAM, valid one cycle after address.

Function
REQ-016 At most one access issued per cycle; grant decision combinational from requests plus registered state.
REQ-017 Only cpu_req: CPU issued, cpu_stall=0, dbg_gnt=0.
REQ-018 Only dbg_req: debug issued, dbg_gnt=1.
REQ-019 Both: CPU wins (cpu_stall=1 only when debug forced per REQ-025), dbg_gnt=0 otherwise.
REQ-020 Neither: mem_wren=0, mem_addr holds last issued address, no rvalid next cycle.
REQ-021 mem_addr/mem_data/mem_wren mux from granted port; mem_wren=1 only for granted write.
REQ-022 Read-owner register (NONE/CPU/DBG) set on each issued read, NONE on write or idle.
REQ-023 Owner CPU: cpu_rvalid=1, cpu_rdata=mem_q next cycle; Owner DBG: dbg_rvalid=1, dbg_rdata=mem_q; rdata of non-owner held at last value.
REQ-024 Writes produce no rvalid; read-after-write same address on next cycle returns new data (RAM write-first not required; arbiter adds no bypass).
REQ-025 Starvation counter (4-bit): +1 each cycle dbg_req=1 and dbg_gnt=0, saturating at MAX_WAIT; cleared when dbg_gnt=1 or dbg_req=0; when equal MAX_WAIT and dbg_req=1, debug wins over CPU and cpu_stall=1.
REQ-026 Requests deasserted while stalled/waiting: no access issued, counter cleared per REQ-025.

Reset
REQ-027 Reset: owner=NONE, counter=0, cpu_rvalid=dbg_rvalid=0, cpu_rdata=dbg_rdata=0, mem_addr=0.
REQ-028 While reset=1: mem_wren=0, dbg_gnt=0, cpu_stall=0, no access issued regardless of requests.
REQ-029 Reset asserted one cycle after a read issue: pending rvalid suppressed.

Configuration
REQ-030 Macro DMEM_ARB_STARVE_EN defined: starvation counter and forced grant per REQ-025 present.
REQ-031 Macro undefined: no counter; fixed CPU priority, cpu_stall constant 0, debug granted only when cpu_req=0.

Structure
REQ-032 Shared package dmem_pkg holds read-owner enum (OWN_NONE, OWN_CPU, OWN_DBG) and default ADDR_W/DATA_W constants.
REQ-033 One sub-module dmem_starve_cnt implements the saturating counter; instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-034 CPU write addr 0x10 data 0xDEADBEEF, then CPU read 0x10 -> mem_wren=1 cycle 0; cpu_rvalid=1, cpu_rdata=0xDEADBEEF cycle 2.
REQ-035 Debug-only read addr 0x3F preloaded 0x12345678 -> dbg_gnt=1 cycle 0, dbg_rvalid=1 with 0x12345678 cycle 1, cpu_rvalid=0.
REQ-036 Both requesting continuously, MAX_WAIT=4, macro on -> CPU issued cycles 0-3, cycle 4 dbg_gnt=1 and cpu_stall=1, cycle 5 CPU resumes.
REQ-037 Same stimulus, macro off -> dbg_gnt never 1, cpu_stall always 0.
REQ-038 CPU read issued, reset asserted next cycle -> cpu_rvalid=0, all outputs at reset values, mem_wren=0.
REQ-039 Back-to-back alternating CPU/debug reads of 0x01/0x02 -> each rvalid on correct port only, data matches RAM contents.
